// File: rtl/wb_data_select_reg.sv
// Registered write-back source selector: picks one of NUM_SRC sources, stalls on late
// sources (mult/div HI/LO) until valid or timeout, then issues a one-cycle regfile write.
module wb_data_select_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SRC   = 8,
  parameter int unsigned       SEL_W     = 3,
  parameter int unsigned       ADDR_W    = 5,
  parameter logic [DATA_W-1:0] CONST_VAL = 'hE3,
  parameter int unsigned       WAIT_MAX  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req,
  input  logic [SEL_W-1:0]          sel,
  input  logic [ADDR_W-1:0]         dest_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      busy,
  output logic                      err_sel,
  output logic                      err_timeout
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StWait} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] addr_q;

  logic              sel_ok;
  logic              req_valid, wait_valid;
  logic [DATA_W-1:0] req_data, wait_data;

  // Slice 0 is replaced by CONST_VAL and is always valid, so its inputs are never read.
  logic unused_src0;
  assign unused_src0 = ^{src_data[DATA_W-1:0], src_valid[0]};

  assign sel_ok = 32'(sel) < NUM_SRC;

  always_comb begin
    req_data   = CONST_VAL;
    req_valid  = 1'b1;
    wait_data  = CONST_VAL;
    wait_valid = 1'b1;
    for (int unsigned i = 1; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        req_data  = src_data[i*DATA_W +: DATA_W];
        req_valid = src_valid[i];
      end
      if (sel_q == SEL_W'(i)) begin
        wait_data  = src_data[i*DATA_W +: DATA_W];
        wait_valid = src_valid[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
      busy        <= 1'b0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rf_we       <= 1'b0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state_q)
        StIdle, StWrite: begin
          busy    <= 1'b0;
          state_q <= StIdle;
          if (wr_req) begin
            if (!sel_ok) begin
              err_sel <= 1'b1;
            end else if (req_valid) begin
              // $zero still completes and updates the held address/data, just without a write
              rf_we    <= (dest_addr != '0);
              rf_addr  <= dest_addr;
              rf_wdata <= req_data;
              state_q  <= StWrite;
            end else begin
              sel_q   <= sel;
              addr_q  <= dest_addr;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (wait_valid) begin
            rf_we    <= (addr_q != '0);
            rf_addr  <= addr_q;
            rf_wdata <= wait_data;
            busy     <= 1'b0;
            state_q  <= StWrite;
          end else if (cnt_q == CntW'(WAIT_MAX - 1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_select_reg.sv
// Bench for wb_data_select_reg: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_wb_data_select_reg;

  localparam int NSRC     = 7;
  localparam int WAIT_MAX = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_req;
  logic [2:0]       sel;
  logic [4:0]       dest_addr;
  logic [NSRC*32-1:0] src_data;
  logic [NSRC-1:0]  src_valid;
  logic             rf_we, busy, err_sel, err_timeout;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  wb_data_select_reg #(
    .DATA_W   (32),
    .NUM_SRC  (NSRC),
    .SEL_W    (3),
    .ADDR_W   (5),
    .CONST_VAL(32'hE3),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .sel        (sel),
    .dest_addr  (dest_addr),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .err_sel    (err_sel),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one pending request at most, counted in waited cycles.
  logic        exp_we, exp_busy, exp_esel, exp_eto;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  bit          pend;
  int          psel, waited;
  logic [4:0]  paddr;

  function automatic logic src_ok(input int s);
    return (s == 0) ? 1'b1 : src_valid[s];
  endfunction

  function automatic logic [31:0] src_val(input int s);
    return (s == 0) ? 32'hE3 : src_data[s*32 +: 32];
  endfunction

  always @(posedge clk) begin : model
    int  s;
    bit  np;
    s = int'(sel);
    np = pend;
    if (reset) begin
      exp_we <= 0; exp_addr <= 0; exp_data <= 0; exp_busy <= 0; exp_esel <= 0; exp_eto <= 0;
      pend <= 0; waited <= 0;
    end else begin
      exp_we <= 0; exp_esel <= 0; exp_eto <= 0;
      if (!pend) begin
        if (wr_req) begin
          if (s >= NSRC) exp_esel <= 1;
          else if (src_ok(s)) begin
            exp_we <= (dest_addr != 0); exp_addr <= dest_addr; exp_data <= src_val(s);
          end else begin
            np = 1; psel <= s; paddr <= dest_addr; waited <= 0;
          end
        end
      end else if (src_ok(psel)) begin
        exp_we <= (paddr != 0); exp_addr <= paddr; exp_data <= src_val(psel); np = 0;
      end else if (waited + 1 == WAIT_MAX) begin
        exp_eto <= 1; np = 0;
      end else begin
        waited <= waited + 1;
      end
      pend     <= np;
      exp_busy <= np;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_we", {31'b0, rf_we}, {31'b0, exp_we});
      chk("m_addr", {27'b0, rf_addr}, {27'b0, exp_addr});
      chk("m_wdata", rf_wdata, exp_data);
      chk("m_busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("m_err_sel", {31'b0, err_sel}, {31'b0, exp_esel});
      chk("m_err_timeout", {31'b0, err_timeout}, {31'b0, exp_eto});
      chk("pulse_excl", {30'b0, 2'(rf_we) + 2'(err_sel) + 2'(err_timeout)} > 1, 0);
    end
  end

  task automatic req(input logic [2:0] s, input logic [4:0] a);
    wr_req = 1; sel = s; dest_addr = a;
    @(negedge clk);
    wr_req = 0;
  endtask

  initial begin
    int busy_cycles;
    bit seen;
    reset = 1; wr_req = 0; sel = 0; dest_addr = 0; src_data = '0; src_valid = '0;
    @(negedge clk);
    cmp_on = 1;
    @(negedge clk);
    chk("reset_we", {31'b0, rf_we}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_wdata", rf_wdata, 0);
    reset = 0;

    // 1: immediate write from source 6
    src_data[6*32 +: 32] = 32'h1234_5678; src_valid[6] = 1;
    req(3'd6, 5'd8);
    chk("t1_we", {31'b0, rf_we}, 1);
    chk("t1_addr", {27'b0, rf_addr}, 8);
    chk("t1_wdata", rf_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("t1_we_pulse", {31'b0, rf_we}, 0);
    chk("t1_addr_held", {27'b0, rf_addr}, 8);

    // 2: constant source
    req(3'd0, 5'd3);
    chk("t2_we", {31'b0, rf_we}, 1);
    chk("t2_wdata", rf_wdata, 32'h0000_00E3);

    // 3: late LO source; valid rises in the sixth wait cycle; mid-wait request ignored
    src_data[2*32 +: 32] = 32'hCAFE_BABE; src_valid[2] = 0;
    req(3'd2, 5'd9);
    busy_cycles = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) busy_cycles++;
      if (k == 2) begin wr_req = 1; sel = 3'd6; dest_addr = 5'd20; end
      else wr_req = 0;
      if (k == 5) src_valid[2] = 1;
      @(negedge clk);
    end
    wr_req = 0; src_valid[2] = 0;
    chk("t3_busy_cycles", busy_cycles, 6);
    chk("t3_we", {31'b0, rf_we}, 1);
    chk("t3_addr", {27'b0, rf_addr}, 9);
    chk("t3_wdata", rf_wdata, 32'hCAFE_BABE);

    // 4: timeout, then out-of-range select
    src_valid[3] = 0;
    req(3'd3, 5'd11);
    busy_cycles = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (busy) busy_cycles++;
      if (err_timeout) seen = 1;
      else @(negedge clk);
    end
    chk("t4_timeout_seen", {31'b0, seen}, 1);
    chk("t4_busy_cycles", busy_cycles, WAIT_MAX);
    chk("t4_no_write_addr", {27'b0, rf_addr}, 9);
    req(3'd7, 5'd12);
    chk("t4_err_sel", {31'b0, err_sel}, 1);
    chk("t4_err_sel_we", {31'b0, rf_we}, 0);

    // 5: $zero destination, back-to-back writes, reset mid-wait
    src_data[5*32 +: 32] = 32'h0000_55AA; src_valid[5] = 1;
    req(3'd5, 5'd0);
    chk("t5_zero_we", {31'b0, rf_we}, 0);
    chk("t5_zero_wdata", rf_wdata, 32'h0000_55AA);
    chk("t5_zero_addr", {27'b0, rf_addr}, 0);
    wr_req = 1; sel = 3'd6;
    for (int a = 1; a <= 3; a++) begin
      dest_addr = 5'(a);
      @(negedge clk);
      chk("t5_b2b_we", {31'b0, rf_we}, 1);
      chk("t5_b2b_addr", {27'b0, rf_addr}, 32'(a));
    end
    wr_req = 0;
    src_valid[4] = 0;
    req(3'd4, 5'd7);
    chk("t5_wait_busy", {31'b0, busy}, 1);
    @(negedge clk);
    reset = 1; src_valid[4] = 1;
    @(negedge clk);
    chk("t5_rst_busy", {31'b0, busy}, 0);
    chk("t5_rst_we", {31'b0, rf_we}, 0);
    reset = 0;
    @(negedge clk);
    chk("t5_after_rst_we", {31'b0, rf_we}, 0);
    chk("t5_after_rst_busy", {31'b0, busy}, 0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
